// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive bit path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } rx_state_t;

  // Idle (J) line level; also the NRZI reference after EOP.
  localparam logic NRZI_IDLE = 1'b1;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

  // One serial CRC16 step; crc[15] holds the highest-order coefficient.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Serial-in parallel-out shift register, resets to all ones.
// SHIFT_MSB=0 shifts right (new bit enters at the MSB end).
module flex_stp_sr #(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  // Shift one bit per enable in the configured direction.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out <= '1;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
      end else begin
        parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/usb_rx_sipo_decoder.sv
// USB receive path: NRZI decode, SYNC check, bit unstuffing, LSB-first
// byte assembly and packet end/error reporting.
// Optional CRC16 residual check is built when USB_RX_CRC16_EN is defined.
module usb_rx_sipo_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned STUFF_LEN = 6,
  parameter int unsigned SYNC_LEN  = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                bit_strobe,
  input  logic                d_line,
  input  logic                eop,
  output logic                rx_active,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                byte_valid,
  output logic                eop_done,
  output logic                byte_err,
  output logic                stuff_err,
  output logic                crc_ok
);

  localparam int unsigned BIT_CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int unsigned ONES_W    = $clog2(STUFF_LEN + 1);
  localparam int unsigned SYNC_W    = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(NUM_BITS - 1);
  localparam logic [ONES_W-1:0]    STUFF_AT  = ONES_W'(STUFF_LEN);
  localparam logic [SYNC_W-1:0]    SYNC_LAST = SYNC_W'(SYNC_LEN - 1);

  rx_state_t            state_q;
  rx_state_t            state_n;
  logic                 prev_line;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [ONES_W-1:0]    ones_cnt;
  logic [SYNC_W-1:0]    sync_cnt;
  logic [NUM_BITS-1:0]  shift_q;

  logic strobe_c;
  logic dbit_c;
  logic sync_start_c;
  logic sync_adv_c;
  logic stuff_drop_c;
  logic stuff_err_c;
  logic shift_c;
  logic byte_done_c;
  logic eop_done_c;
  logic byte_err_c;

  // A bit coinciding with EOP is discarded.
  assign strobe_c = bit_strobe & ~eop;
  // NRZI: no transition decodes as 1.
  assign dbit_c   = (d_line == prev_line);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    if (eop) begin
      state_n = IDLE;
    end else if (bit_strobe) begin
      case (state_q)
        IDLE: if (!dbit_c) state_n = SYNC;
        SYNC: begin
          if (sync_cnt == SYNC_LAST) begin
            state_n = dbit_c ? DATA : ERR;
          end else if (dbit_c) begin
            state_n = ERR;
          end
        end
        DATA: if ((ones_cnt == STUFF_AT) && dbit_c) state_n = ERR;
        ERR:  state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  // Per-cycle datapath decisions derived from the current state.
  always_comb begin
    sync_start_c = 1'b0;
    sync_adv_c   = 1'b0;
    stuff_drop_c = 1'b0;
    stuff_err_c  = 1'b0;
    shift_c      = 1'b0;
    byte_done_c  = 1'b0;
    eop_done_c   = 1'b0;
    byte_err_c   = 1'b0;
    if (strobe_c) begin
      case (state_q)
        IDLE: sync_start_c = ~dbit_c;
        SYNC: sync_adv_c = ~dbit_c & (sync_cnt != SYNC_LAST);
        DATA: begin
          if (ones_cnt == STUFF_AT) begin
            stuff_drop_c = ~dbit_c;
            stuff_err_c  = dbit_c;
          end else begin
            shift_c     = 1'b1;
            byte_done_c = (bit_cnt == LAST_BIT);
          end
        end
        default: ;
      endcase
    end
    if (eop && (state_q == DATA)) begin
      eop_done_c = (bit_cnt == '0);
      byte_err_c = (bit_cnt != '0);
    end
  end

  // Line history and bit/ones/SYNC counters.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_line <= NRZI_IDLE;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      sync_cnt  <= '0;
    end else begin
      if (eop) begin
        prev_line <= NRZI_IDLE;
      end else if (bit_strobe) begin
        prev_line <= d_line;
      end

      if (sync_start_c) begin
        sync_cnt <= SYNC_W'(1);
      end else if (sync_adv_c) begin
        sync_cnt <= sync_cnt + SYNC_W'(1);
      end

      if (eop || sync_start_c) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else if (stuff_drop_c) begin
        ones_cnt <= '0;
      end else if (shift_c) begin
        bit_cnt  <= byte_done_c ? '0 : bit_cnt + BIT_CNT_W'(1);
        ones_cnt <= dbit_c ? ones_cnt + ONES_W'(1) : '0;
      end
    end
  end

  // Registered outputs; rx_data captures the byte as its last bit shifts in.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_active  <= 1'b0;
      rx_data    <= '1;
      byte_valid <= 1'b0;
      eop_done   <= 1'b0;
      byte_err   <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      rx_active  <= (state_n != IDLE);
      byte_valid <= byte_done_c;
      eop_done   <= eop_done_c;
      byte_err   <= byte_err_c;
      stuff_err  <= stuff_err_c;
      if (byte_done_c) begin
        rx_data <= NUM_BITS'({dbit_c, shift_q} >> 1);
      end
    end
  end

  flex_stp_sr #(
    .NUM_BITS (NUM_BITS),
    .SHIFT_MSB(1'b0)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_c),
    .serial_in   (dbit_c),
    .parallel_out(shift_q)
  );

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc_q;
  logic        pid_done;

  // CRC over data bits following the PID byte; verdict latched at clean EOP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q    <= CRC16_INIT;
      pid_done <= 1'b0;
      crc_ok   <= 1'b0;
    end else begin
      if (sync_start_c) begin
        crc_ok <= 1'b0;
      end else if (eop_done_c) begin
        crc_ok <= (crc_q == CRC16_RESIDUAL);
      end

      if (sync_start_c) begin
        pid_done <= 1'b0;
      end else if (byte_done_c) begin
        pid_done <= 1'b1;
      end

      if ((state_q == SYNC) && (state_n == DATA)) begin
        crc_q <= CRC16_INIT;
      end else if (shift_c && pid_done) begin
        crc_q <= crc16_step(crc_q, dbit_c);
      end
    end
  end
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_sipo_decoder.sv
// Scoreboard bench for usb_rx_sipo_decoder: packets are built from bytes,
// stuffed and NRZI-encoded here; expected events are queued at send time
// and a negedge monitor pops and compares them as the DUT pulses.
module tb_usb_rx_sipo_decoder;

  localparam int K_BYTE = 0;
  localparam int K_DONE = 1;
  localparam int K_BERR = 2;
  localparam int K_SERR = 3;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       bit_strobe;
  logic       d_line;
  logic       eop;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       byte_valid;
  logic       eop_done;
  logic       byte_err;
  logic       stuff_err;
  logic       crc_ok;

  always #5 clk = ~clk;

  usb_rx_sipo_decoder #(
    .NUM_BITS (8),
    .STUFF_LEN(6),
    .SYNC_LEN (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bit_strobe(bit_strobe),
    .d_line    (d_line),
    .eop       (eop),
    .rx_active (rx_active),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .eop_done  (eop_done),
    .byte_err  (byte_err),
    .stuff_err (stuff_err),
    .crc_ok    (crc_ok)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       crc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic line;          // current encoded line level
  int   ones;          // run of data ones since last zero/stuff
  bit   pkt_bits[$];   // data bits of the current packet, stuff removed

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [15:0] crc_over(input int lo, input int hi);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = lo; i < hi; i++) begin
      c = {c[14:0], 1'b0} ^ ((pkt_bits[i] ^ c[15]) ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  // Packet is good when its last 16 bits are the complemented CRC of the
  // bits between the PID and that field, highest coefficient first.
  function automatic logic model_crc_ok();
`ifdef USB_RX_CRC16_EN
    logic [15:0] c;
    int n;
    n = pkt_bits.size();
    if (n < 24) return 1'b0;
    c = crc_over(8, n - 16);
    for (int i = 0; i < 16; i++) begin
      if (pkt_bits[n - 16 + i] != ~c[15 - i]) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one decoded bit on the line (NRZI), with a random gap first.
  task automatic send_dbit(input logic b);
    repeat ($urandom_range(0, 2)) tick();
    if (!b) line = ~line;
    bit_strobe = 1'b1;
    d_line     = line;
    tick();
    bit_strobe = 1'b0;
  endtask

  task automatic send_data_bit(input logic b, input bit chk_byte);
    send_dbit(b);
    pkt_bits.push_back(b);
    if (chk_byte) check("byte_valid_latency", 32'(byte_valid), 32'd1);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_dbit(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] x);
    exp_t e;
    e.kind = K_BYTE;
    e.data = x;
    e.crc  = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) send_data_bit(x[i], i == 7);
  endtask

  task automatic send_sync();
    repeat ($urandom_range(0, 2)) send_dbit(1'b1);
    repeat (7) send_dbit(1'b0);
    send_dbit(1'b1);
    ones = 0;
    pkt_bits.delete();
  endtask

  task automatic send_eop(input bit with_strobe);
    repeat ($urandom_range(0, 2)) tick();
    eop        = 1'b1;
    bit_strobe = with_strobe;
    d_line     = 1'($urandom_range(0, 1));
    tick();
    eop        = 1'b0;
    bit_strobe = 1'b0;
    line       = 1'b1;
  endtask

  task automatic end_clean(input bit with_strobe);
    exp_t e;
    e.kind = K_DONE;
    e.data = 8'h00;
    e.crc  = model_crc_ok();
    exp_q.push_back(e);
    send_eop(with_strobe);
    check("rx_active_after_eop", 32'(rx_active), 32'd0);
  endtask

  task automatic crc_packet(input int npay, input bit good);
    logic [15:0] c;
    logic [7:0]  b0;
    logic [7:0]  b1;
    send_sync();
    send_byte(8'($urandom));
    repeat (npay) send_byte(8'($urandom));
    c = crc_over(8, pkt_bits.size());
    for (int i = 0; i < 8; i++) begin
      b0[i] = ~c[15 - i];
      b1[i] = ~c[7 - i];
    end
    if (!good) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
    end
    send_byte(b0);
    send_byte(b1);
    end_clean(1'($urandom_range(0, 1)));
  endtask

  task automatic byte_err_pkt(input int nbytes, input int nbits, input bit with_strobe);
    exp_t e;
    send_sync();
    repeat (nbytes) send_byte(8'($urandom));
    for (int i = 0; i < nbits; i++) send_data_bit(1'($urandom_range(0, 1)), 1'b0);
    e.kind = K_BERR;
    e.data = 8'h00;
    e.crc  = 1'b0;
    exp_q.push_back(e);
    send_eop(with_strobe);
  endtask

  // After whole bytes: a data 0 then seven 1s; the seventh 1 is illegal.
  task automatic stuff_err_pkt(input int nbytes);
    exp_t e;
    send_sync();
    repeat (nbytes) send_byte(8'($urandom));
    send_dbit(1'b0);
    repeat (6) send_dbit(1'b1);
    e.kind = K_SERR;
    e.data = 8'h00;
    e.crc  = 1'b0;
    exp_q.push_back(e);
    send_dbit(1'b1);
    check("rx_active_in_err", 32'(rx_active), 32'd1);
    repeat ($urandom_range(0, 5)) send_dbit(1'($urandom_range(0, 1)));
    send_eop(1'b0);
    check("rx_active_err_eop", 32'(rx_active), 32'd0);
  endtask

  // pos zeros (1..7) then the wrong SYNC bit.
  task automatic sync_err_pkt(input int pos);
    repeat ($urandom_range(0, 2)) send_dbit(1'b1);
    repeat (pos) send_dbit(1'b0);
    send_dbit(pos == 7 ? 1'b0 : 1'b1);
    check("rx_active_sync_err", 32'(rx_active), 32'd1);
    repeat ($urandom_range(0, 4)) send_dbit(1'($urandom_range(0, 1)));
    send_eop(1'b0);
    check("rx_active_sync_eop", 32'(rx_active), 32'd0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  initial begin
    int   k;
    exp_t e;
    forever begin
      @(negedge clk);
      if (byte_valid || eop_done || byte_err || stuff_err) begin
        k = byte_valid ? K_BYTE : eop_done ? K_DONE : byte_err ? K_BERR : K_SERR;
        check("single_pulse", 32'(byte_valid) + 32'(eop_done) + 32'(byte_err) + 32'(stuff_err), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", k, $time);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(k), 32'(e.kind));
          if (e.kind == K_BYTE) check("rx_data", 32'(rx_data), 32'(e.data));
          if (e.kind == K_DONE) check("crc_ok", 32'(crc_ok), 32'(e.crc));
          if (e.kind == K_DONE || e.kind == K_BERR) check("rx_active_end", 32'(rx_active), 32'd0);
          if (e.kind == K_SERR) check("rx_active_serr", 32'(rx_active), 32'd1);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int t;
    n_rst      = 1'b0;
    bit_strobe = 1'b0;
    d_line     = 1'b1;
    eop        = 1'b0;
    line       = 1'b1;
    ones       = 0;
    repeat (3) tick();
    check("rst_rx_active", 32'(rx_active), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'hFF);
    check("rst_pulses", {28'd0, byte_valid, eop_done, byte_err, stuff_err}, 32'd0);
    check("rst_crc_ok", 32'(crc_ok), 32'd0);
    n_rst = 1'b1;
    tick();

    // Directed packets.
    send_sync(); send_byte(8'hA5); end_clean(1'b0);
    send_sync(); send_byte(8'h7E); end_clean(1'b0);
    send_sync(); send_byte(8'hFF); send_byte(8'hFF); end_clean(1'b1);
    send_sync(); send_byte(8'hC3); send_byte(8'h00); send_byte(8'h00); end_clean(1'b0);
    send_sync(); send_byte(8'hC3); send_byte(8'h00); send_byte(8'h01); end_clean(1'b0);
    stuff_err_pkt(1);
    sync_err_pkt(3);
    sync_err_pkt(7);
    byte_err_pkt(0, 3, 1'b0);
    byte_err_pkt(1, 7, 1'b1);

    // Reset in DATA with three bits of a byte collected.
    send_sync(); send_byte(8'h5A);
    repeat (3) send_data_bit(1'($urandom_range(0, 1)), 1'b0);
    n_rst = 1'b0;
    tick();
    check("midrst_rx_active", 32'(rx_active), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'hFF);
    check("midrst_pulses", {28'd0, byte_valid, eop_done, byte_err, stuff_err}, 32'd0);
    n_rst = 1'b1;
    line  = 1'b1;
    tick();

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 4))
        0, 1: crc_packet(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        2:    byte_err_pkt(int'($urandom_range(0, 2)), int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
        3:    stuff_err_pkt(int'($urandom_range(0, 2)));
        default: sync_err_pkt(int'($urandom_range(1, 7)));
      endcase
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
